// File: rtl/ic_irq_arbiter.sv
// rtl/ic_irq_arbiter.sv - programmable-priority round-robin IRQ arbiter with present/accept/EOI sequencing
// Optional service watchdog enabled by defining IC_WATCHDOG_EN.
module ic_irq_arbiter #(
  parameter int NUM_SRC        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] irq_requests,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [2:0] cfg_wdata,
  output logic       irq_valid,
  input  logic       irq_ready,
  output logic [2:0] irq_id,
  output logic [1:0] irq_prio,
  input  logic       eoi,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0] state;
  logic [7:0] pending;
  logic [7:0] prev_irq;
  logic [7:0] enable;
  logic [1:0] prio [8];
  logic [2:0] rr_ptr;

  logic [7:0] rise;
  logic [7:0] cand;
  logic [7:0] pending_nxt;
  logic       win_found;
  logic [2:0] win_id;
  logic [1:0] win_prio;
  logic [2:0] idx;

  assign rise      = irq_requests & ~prev_irq & enable;
  assign cand      = pending & enable;
  assign irq_valid = (state == PRESENT);
  assign busy      = (state == SERVICE);

  // A new edge in the accept cycle re-sets the bit; disabling a source always clears it.
  always_comb begin
    pending_nxt = pending;
    if (state == PRESENT && irq_ready)
      pending_nxt[irq_id] = 1'b0;
    pending_nxt = pending_nxt | rise;
    if (cfg_we && !cfg_wdata[2])
      pending_nxt[cfg_addr] = 1'b0;
  end

  // Scan from rr_ptr; only a strictly higher priority displaces the first candidate found.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    win_prio  = 2'd0;
    idx       = rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr + 3'(k);
      if (cand[idx] && (!win_found || prio[idx] > win_prio)) begin
        win_found = 1'b1;
        win_id    = idx;
        win_prio  = prio[idx];
      end
    end
  end

`ifdef IC_WATCHDOG_EN
  logic [7:0] svc_cnt;
  logic       timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pending  <= 8'h00;
      prev_irq <= 8'h00;
      enable   <= 8'hff;
      rr_ptr   <= 3'd0;
      irq_id   <= 3'd0;
      irq_prio <= 2'd0;
      for (int i = 0; i < 8; i++)
        prio[i] <= 2'd0;
`ifdef IC_WATCHDOG_EN
      svc_cnt   <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      prev_irq <= irq_requests;
      pending  <= pending_nxt;
      if (cfg_we) begin
        enable[cfg_addr] <= cfg_wdata[2];
        prio[cfg_addr]   <= cfg_wdata[1:0];
      end
`ifdef IC_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            irq_id   <= win_id;
            irq_prio <= win_prio;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            rr_ptr <= irq_id + 3'd1;
            state  <= SERVICE;
`ifdef IC_WATCHDOG_EN
            svc_cnt <= 8'd0;
`endif
          end
        end
        SERVICE: begin
          if (eoi) begin
            state <= IDLE;
`ifdef IC_WATCHDOG_EN
          end else if (svc_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            svc_cnt <= svc_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ic_irq_arbiter.md
Name: ic_irq_arbiter

Overview:
Programmable-priority interrupt arbiter and CPU-handshake sequencer for the interrupt subsystem. It sits between the raw interrupt request lines and the processor model, and replaces the fixed IRQ0-first encoder with per-source enable and priority. Equal-priority sources are served round-robin. Each interrupt is sequenced through a present / accept / end-of-interrupt (EOI) protocol with a service watchdog.

Parameters:
NUM_SRC, 8, number of interrupt sources (IDs are 3 bits, fixed at 8 for this revision)
TIMEOUT_CYCLES, 16, maximum SERVICE cycles allowed before a forced completion (legal range 2..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
irq_requests  input  8  level interrupt lines, synchronous to clk
cfg_we  input  1  configuration write strobe
cfg_addr  input  3  source index being configured
cfg_wdata  input  3  [2] enable, [1:0] priority (3 = highest)
irq_valid  output  1  interrupt presented to CPU
irq_ready  input  1  CPU accepts the presented interrupt
irq_id  output  3  presented source ID
irq_prio  output  2  presented source priority
eoi  input  1  CPU end-of-interrupt pulse
busy  output  1  high in SERVICE state
timeout_err  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values:
  - irq_valid=0, irq_id=0, irq_prio=0, busy=0, timeout_err=0.
  - pending=0, prev_irq=0, rr_ptr=0, FSM=IDLE.
  - All sources enabled, all priorities 0.
- Edge detect:
  - pending[i] sets at the edge where irq_requests[i]=1, prev_irq[i]=0 and enable[i]=1.
  - prev_irq is always updated, including while the source is disabled.
  - A rising edge on an already-pending source is absorbed; no counting.
- Configuration:
  - cfg_we writes enable/priority for cfg_addr at the clock edge.
  - Disabling a source clears its pending bit at the same edge.
  - A new configuration takes effect from the next arbitration.
- Arbitration, evaluated in IDLE only:
  - Candidate set = pending & enable.
  - The winner has the highest priority in the set.
  - Ties go to the first candidate found scanning upward from rr_ptr, wrapping 7 to 0.
- FSM (3 states):
  - IDLE: if any candidate exists, register irq_id/irq_prio from the winner and go to PRESENT; otherwise stay.
  - PRESENT:
    - irq_valid=1.
    - irq_id and irq_prio are held stable; no re-arbitration, even if a higher-priority source arrives.
    - On irq_valid && irq_ready: clear pending[irq_id], set rr_ptr=(irq_id+1) mod 8, go to SERVICE.
    - If the same source sees a new rising edge in the accept cycle, the set wins and pending stays 1.
  - SERVICE:
    - busy=1, irq_valid=0.
    - On eoi, go to IDLE. The next presentation can occur at the earliest one cycle after leaving SERVICE.
- eoi outside SERVICE is ignored. irq_ready outside PRESENT is ignored.
- Latency:
  - Rising edge sampled at clock edge E: pending=1 after E, irq_valid=1 after E+1 (when in IDLE).
  - Minimum of 2 cycles from input to presentation.
- Reset mid-operation: asynchronous return to reset values from any state. An in-flight interrupt is lost and no timeout_err is issued.

Optional Feature:
Macro IC_WATCHDOG_EN.
- Defined:
  - An 8-bit service counter clears on SERVICE entry and increments each SERVICE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without eoi, the FSM goes to IDLE and timeout_err pulses for one cycle on that transition.
  - An eoi in the expiry cycle takes precedence: normal exit, no pulse.
- Not defined: no counter. SERVICE waits indefinitely for eoi, and timeout_err is tied to 0.

Test Plan:
1. Reset, then pulse irq_requests=8'h01 with irq_ready=1 -> irq_valid high 2 cycles after the edge, irq_id=0, irq_prio=0; busy=1 after accept; eoi -> IDLE and irq_valid stays 0.
2. Set prio[5]=3 and prio[2]=1; raise bits 2 and 5 together -> serves ID 5 first, then ID 2 after eoi.
3. All priorities 0; hold bits 1, 3, 6 with repeated re-edges and immediate accept/eoi -> serve order 1, 3, 6, 1, 3, 6 (round-robin).
4. While ID 4 is in PRESENT with irq_ready=0, raise source 0 at priority 3 -> irq_id stays 4 until accepted; ID 0 is presented next.
5. Disable source 7 via cfg while it is pending -> it is never presented; re-enable and give a new edge -> presented.
6. With IC_WATCHDOG_EN and TIMEOUT_CYCLES=16: accept ID 3, withhold eoi -> timeout_err pulses once after 16 SERVICE cycles, busy drops, and the next pending source is presented. Without the macro -> busy stays high and no pulse.
